// File: rtl/int_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Memory-mapped interrupt controller. Rising edges on the irq
//               lines latch into a sticky STATUS register (write-1-to-clear),
//               are gated by MASK (bit 0 = global enable) and raise the
//               interrupt request towards the CPU. An acknowledge drops the
//               request and clears the global enable until software sets it
//               again. Register select: addr 0 = MASK, addr 1 = STATUS.
//               Optional macro INT_CTRL_SYNC_EN inserts a two-flop
//               synchronizer on every irq line ahead of edge detection.
//               The CPU-facing request is named int_req because `int` is a
//               reserved word in SystemVerilog.
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl #(
    parameter int NLINES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              addr,
    input  logic [1:0]        drw,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    input  logic [NLINES-1:0] irq,
    output logic              int_req,
    input  logic              int_ack
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Line 0 has no source: it never contributes to pending.
    localparam logic [NLINES-1:0] C_LINE_MASK = {{(NLINES-1){1'b1}}, 1'b0};

    state_t            state_q, state_d;
    logic [NLINES-1:0] mask_q, mask_d;
    logic [NLINES-1:0] status_q, status_d;
    logic [NLINES-1:0] irq_q, irq_d;
    logic [NLINES-1:0] irq_s;
    logic              wr_mask, wr_status, pending;

    // Upper write-data bits beyond NLINES carry no storage.
    logic unused_din;
    assign unused_din = ^din;

`ifdef INT_CTRL_SYNC_EN
    logic [NLINES-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous peripheral lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq;
`endif

    assign wr_mask   = en & drw[0] & ~addr;
    assign wr_status = en & drw[0] &  addr;
    assign pending   = (|(status_q & mask_q & C_LINE_MASK)) & mask_q[0];
    assign int_req   = (state_q == ST_ASSERT);

    // State, register file and edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            status_q <= '0;
            irq_q    <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    // Sticky status: W1C first, then new edges so a same-cycle set wins.
    always_comb begin
        irq_d    = irq_s;
        status_d = status_q;
        if (wr_status) begin
            status_d = status_q & ~din[NLINES-1:0];
        end
        status_d    = status_d | (irq_s & ~irq_q);
        status_d[0] = 1'b0;
    end

    // Handshake FSM; an ack also clears the global enable, overriding any write.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        if (wr_mask) begin
            mask_d = din[NLINES-1:0];
        end
        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (int_ack) begin
                    state_d   = ST_SERVICE;
                    mask_d[0] = 1'b0;
                end else if (!pending) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_mask && din[0]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Combinational read mux; zero when not selected for read.
    always_comb begin
        dout = '0;
        if (en && drw[1]) begin
            dout[NLINES-1:0] = addr ? status_q : mask_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Self-checking bench for int_ctrl: directed scenarios followed
//               by random register traffic, irq activity and acks, compared
//               against a behavioural model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    localparam int NL = 8;
`ifdef INT_CTRL_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    localparam int PH_QUIET    = 0;
    localparam int PH_RAISED   = 1;
    localparam int PH_HANDLING = 2;

    logic          clk = 1'b0;
    logic          rst, en, addr, int_ack;
    logic [1:0]    drw;
    logic [31:0]   din, dout;
    logic [NL-1:0] irq;
    logic          int_req;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [NL-1:0] m_mask, m_status, m_prev, m_d1, m_d2;
    int            m_phase;
    logic [31:0]   last_dout;

    int_ctrl #(.NLINES(NL)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .addr    (addr),
        .drw     (drw),
        .din     (din),
        .dout    (dout),
        .irq     (irq),
        .int_req (int_req),
        .int_ack (int_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check read data, apply the rules at the edge, check int.
    task automatic cycle(input logic i_rst, input logic i_en, input logic i_addr,
                         input logic [1:0] i_drw, input logic [31:0] i_din,
                         input logic [NL-1:0] i_irq, input logic i_ack);
        logic [31:0]   exp_dout;
        logic [NL-1:0] s, edges, nm, ns;
        logic          pend, wm, ws;
        int            np;
        rst = i_rst; en = i_en; addr = i_addr; drw = i_drw;
        din = i_din; irq = i_irq; int_ack = i_ack;
        #1;
        exp_dout = 32'h0;
        if (i_en && i_drw[1]) exp_dout = {{(32-NL){1'b0}}, (i_addr ? m_status : m_mask)};
        last_dout = dout;
        chk("dout", dout, exp_dout);
        if (i_rst) begin
            m_mask = '0; m_status = '0; m_prev = '0; m_d1 = '0; m_d2 = '0;
            m_phase = PH_QUIET;
        end else begin
            s     = (EXTRA != 0) ? m_d2 : i_irq;
            edges = s & ~m_prev;
            pend  = (((m_status & m_mask) >> 1) != '0) && m_mask[0];
            wm    = i_en && i_drw[0] && !i_addr;
            ws    = i_en && i_drw[0] &&  i_addr;
            np = m_phase;
            if (m_phase == PH_QUIET && pend) np = PH_RAISED;
            else if (m_phase == PH_RAISED && i_ack) np = PH_HANDLING;
            else if (m_phase == PH_RAISED && !pend) np = PH_QUIET;
            else if (m_phase == PH_HANDLING && wm && i_din[0]) np = PH_QUIET;
            nm = m_mask;
            if (wm) nm = i_din[NL-1:0];
            if (m_phase == PH_RAISED && i_ack) nm[0] = 1'b0;
            ns = m_status;
            if (ws) ns = ns & ~i_din[NL-1:0];
            ns = ns | edges;
            ns[0] = 1'b0;
            m_d2 = m_d1; m_d1 = i_irq; m_prev = s;
            m_mask = nm; m_status = ns; m_phase = np;
        end
        @(posedge clk);
        #1;
        chk("int", {31'b0, int_req}, {31'b0, (m_phase == PH_RAISED)});
    endtask

    task automatic idle(input logic [NL-1:0] i_irq, input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, i_irq, 1'b0);
    endtask

    initial begin
        logic [NL-1:0] irq_v;
        logic          r_en, r_addr, r_ack, r_rst;
        logic [1:0]    r_drw;
        logic [31:0]   r_din;
        int            r;

        m_mask = '0; m_status = '0; m_prev = '0; m_d1 = '0; m_d2 = '0;
        m_phase = PH_QUIET; last_dout = '0;

        // Reset, then read both registers
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, '0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, '0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, '0, 1'b0);
        chk("reset_mask", last_dout, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 2'b10, 32'h0, '0, 1'b0);
        chk("reset_status", last_dout, 32'h0);
        chk("reset_int", {31'b0, int_req}, 32'h0);

        // MASK=0x05, one-cycle pulse on irq[2]
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'h5, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 8'h04, 1'b0);
        idle('0, EXTRA);
        chk("lat_not_yet", {31'b0, int_req}, 32'h0);
        idle('0, 1);
        chk("lat_int_high", {31'b0, int_req}, 32'h1);
        cycle(1'b0, 1'b1, 1'b1, 2'b10, 32'h0, '0, 1'b0);
        chk("status_pulse", last_dout, 32'h4);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, '0, 1'b1);
        chk("ack_int_low", {31'b0, int_req}, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, '0, 1'b0);
        chk("ack_mask", last_dout, 32'h4);

        // In SERVICE: clear STATUS bit 2, then re-enable; nothing pending
        cycle(1'b0, 1'b1, 1'b1, 2'b01, 32'h4, '0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'h5, '0, 1'b0);
        idle('0, 3);
        chk("service_quiet", {31'b0, int_req}, 32'h0);

        // MASK=0x09, irq[3] held, then drop GE before the ack
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'h9, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 8'h08, 1'b0);
        idle(8'h08, 1 + EXTRA);
        chk("irq3_int_high", {31'b0, int_req}, 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'h8, 8'h08, 1'b0);
        idle(8'h08, 1);
        chk("ge_drop_int", {31'b0, int_req}, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 2'b10, 32'h0, 8'h08, 1'b0);
        chk("status_kept", last_dout, 32'h8);
        idle('0, 4);

        // W1C of bit 3 in the same cycle the new irq[3] edge is seen
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 8'h08, 1'b0);
        idle(8'h08, EXTRA);
        if (EXTRA == 0) begin
            // irq already rose in the cycle above; redo with the W1C aligned
            idle('0, 2);
        end
        cycle(1'b0, 1'b1, 1'b1, 2'b01, 32'h8, 8'h08, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 2'b10, 32'h0, 8'h08, 1'b0);
        chk("set_wins", last_dout, 32'h8);
        idle('0, 4);

        // MASK=0x03, irq[1] rise, then reset while asserted
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'h3, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 8'h02, 1'b0);
        idle(8'h02, 1 + EXTRA);
        chk("sync_lat_int", {31'b0, int_req}, 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 8'h02, 1'b0);
        chk("rst_int", {31'b0, int_req}, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, '0, 1'b0);
        chk("rst_mask", last_dout, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 2'b10, 32'h0, '0, 1'b0);
        chk("rst_status", last_dout, 32'h0);

        // Random traffic
        irq_v = '0;
        for (int i = 0; i < 3000; i++) begin
            irq_v  = irq_v ^ NL'($urandom & $urandom & $urandom);
            r      = int'($urandom_range(0, 99));
            r_en   = ($urandom_range(0, 9) != 0);
            r_addr = (r >= 20);
            r_drw  = 2'b00;
            r_din  = $urandom;
            if (r < 20) begin
                r_drw = 2'b01;
                r_din[0] = ($urandom_range(0, 9) < 7);
            end else if (r < 35) begin
                r_drw = 2'b01;
            end else if (r < 60) begin
                r_drw  = 2'($urandom_range(2, 3));
                r_addr = $urandom_range(0, 1) != 0;
            end
            if (m_phase == PH_RAISED) r_ack = ($urandom_range(0, 2) == 0);
            else                      r_ack = ($urandom_range(0, 39) == 0);
            r_rst = ($urandom_range(0, 299) == 0);
            cycle(r_rst, r_en, r_addr, r_drw, r_din, irq_v, r_ack);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
